// File: rtl/fill_processor.sv
// ============================================================================
// Module   : fill_processor
// Brief    : Execution-report sequencer, fill pulse generator and position/cash/P&L tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fill_processor_pkg;
   typedef enum logic {SIDE_BUY = 1'b0, SIDE_SELL = 1'b1} order_side_e;
endpackage

module fill_processor
   import fill_processor_pkg::*;
#(
   parameter int QTY_W  = 32,
   parameter int PX_W   = 32,
   parameter int POS_W  = 48,
   parameter int CASH_W = 96
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_er_valid,
   output logic                    o_er_ready,
   input  logic [1:0]              i_er_type,
   input  order_side_e             i_er_side,
   input  logic [QTY_W-1:0]        i_er_qty,
   input  logic [PX_W-1:0]         i_er_price,
   input  logic [31:0]             i_er_seq,
   input  logic [PX_W-1:0]         i_mark_px,
   input  logic                    i_cmd_pos_reset,
   input  logic                    i_cmd_clear_err,
   output logic                    o_fill_valid,
   output order_side_e             o_fill_side,
   output logic [63:0]             o_fill_qty,
   output logic [63:0]             o_fill_notional,
   output logic signed [POS_W-1:0] o_net_position,
   output logic [63:0]             o_current_pnl,
   output logic                    o_pnl_is_loss,
   output logic                    o_seq_gap_flag,
   output logic [63:0]             o_stat_fills,
   output logic [63:0]             o_stat_dups,
   output logic [63:0]             o_stat_gaps
);

   localparam int c_PNL_W = CASH_W + 1;
   localparam logic signed [POS_W:0] c_POS_MAX = {2'b00, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W:0] c_POS_MIN = -c_POS_MAX;

   logic                     r_ready, r_synced, r_gap_flag;
   logic [31:0]              r_exp_seq;
   logic [63:0]              r_stat_fills, r_stat_dups, r_stat_gaps;
   logic                     r_s1_valid;
   order_side_e              r_s1_side;
   logic [QTY_W-1:0]         r_s1_qty;
   logic [63:0]              r_s1_notional;
   logic signed [POS_W-1:0]  r_pos;
   logic signed [CASH_W-1:0] r_cash;
   logic [63:0]              r_pnl_mag;
   logic                     r_pnl_loss;

   logic                     w_accept, w_dup, w_gap, w_apply, w_is_fill;
   logic [31:0]              w_seq_d;
   logic [63:0]              w_notional;
   logic signed [POS_W:0]    w_pos_ext, w_qty_ext, w_pos_sum;
   logic signed [POS_W-1:0]  w_pos_next;
   logic signed [CASH_W-1:0] w_notional_ext;
   logic signed [c_PNL_W-1:0] w_pos_wide, w_mark_wide, w_cash_wide, w_pnl;
   logic [c_PNL_W-1:0]       w_pnl_mag;
   logic [63:0]              w_pnl_clip;

   // Sequence check: distance from the expected number, mod 2^32
   assign w_accept   = i_er_valid & r_ready;
   assign w_seq_d    = i_er_seq - r_exp_seq;
   assign w_dup      = w_accept & r_synced & w_seq_d[31];
   assign w_gap      = w_accept & r_synced & ~w_seq_d[31] & (w_seq_d != 32'd0);
   assign w_apply    = w_accept & ~w_dup;
   assign w_is_fill  = w_apply & ~i_er_type[1];
   assign w_notional = 64'(i_er_qty) * 64'(i_er_price);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready       <= 1'b0;
         r_synced      <= 1'b0;
         r_exp_seq     <= '0;
         r_gap_flag    <= 1'b0;
         r_stat_fills  <= '0;
         r_stat_dups   <= '0;
         r_stat_gaps   <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_side     <= SIDE_BUY;
         r_s1_qty      <= '0;
         r_s1_notional <= '0;
      end else begin
         r_ready    <= 1'b1;
         r_s1_valid <= w_is_fill;
         if (w_is_fill) begin
            r_s1_side     <= i_er_side;
            r_s1_qty      <= i_er_qty;
            r_s1_notional <= w_notional;
            r_stat_fills  <= r_stat_fills + 64'd1;
         end
         if (w_apply) begin
            r_synced  <= 1'b1;
            r_exp_seq <= i_er_seq + 32'd1;
         end
         if (w_dup) r_stat_dups <= r_stat_dups + 64'd1;
         if (w_gap) begin
            r_stat_gaps <= r_stat_gaps + 64'd1;
            r_gap_flag  <= 1'b1;
         end else if (i_cmd_clear_err) begin
            r_gap_flag  <= 1'b0;
         end
      end
   end

   assign w_pos_ext      = {r_pos[POS_W-1], r_pos};
   assign w_qty_ext      = $signed({{(POS_W+1-QTY_W){1'b0}}, r_s1_qty});
   assign w_pos_sum      = (r_s1_side == SIDE_BUY) ? (w_pos_ext + w_qty_ext) : (w_pos_ext - w_qty_ext);
   assign w_notional_ext = $signed({{(CASH_W-64){1'b0}}, r_s1_notional});

   always_comb begin
      w_pos_next = w_pos_sum[POS_W-1:0];
      if (w_pos_sum > c_POS_MAX)      w_pos_next = c_POS_MAX[POS_W-1:0];
      else if (w_pos_sum < c_POS_MIN) w_pos_next = c_POS_MIN[POS_W-1:0];
   end

   // A position reset discards any fill reaching the accumulators in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos  <= '0;
         r_cash <= '0;
      end else if (i_cmd_pos_reset) begin
         r_pos  <= '0;
         r_cash <= '0;
      end else if (r_s1_valid) begin
         r_pos  <= w_pos_next;
         r_cash <= (r_s1_side == SIDE_BUY) ? (r_cash - w_notional_ext) : (r_cash + w_notional_ext);
      end
   end

   assign w_pos_wide  = $signed({{(c_PNL_W-POS_W){r_pos[POS_W-1]}}, r_pos});
   assign w_mark_wide = $signed({{(c_PNL_W-PX_W){1'b0}}, i_mark_px});
   assign w_cash_wide = $signed({r_cash[CASH_W-1], r_cash});
   assign w_pnl       = w_cash_wide + (w_pos_wide * w_mark_wide);
   assign w_pnl_mag   = w_pnl[c_PNL_W-1] ? -w_pnl : w_pnl;
   assign w_pnl_clip  = (|w_pnl_mag[c_PNL_W-1:64]) ? {64{1'b1}} : w_pnl_mag[63:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pnl_mag  <= '0;
         r_pnl_loss <= 1'b0;
      end else begin
         r_pnl_mag  <= w_pnl_clip;
         r_pnl_loss <= w_pnl[c_PNL_W-1];
      end
   end

   assign o_er_ready      = r_ready;
   assign o_fill_valid    = r_s1_valid;
   assign o_fill_side     = r_s1_side;
   assign o_fill_qty      = 64'(r_s1_qty);
   assign o_fill_notional = r_s1_notional;
   assign o_net_position  = r_pos;
   assign o_current_pnl   = r_pnl_mag;
   assign o_pnl_is_loss   = r_pnl_loss;
   assign o_seq_gap_flag  = r_gap_flag;
   assign o_stat_fills    = r_stat_fills;
   assign o_stat_dups     = r_stat_dups;
   assign o_stat_gaps     = r_stat_gaps;

endmodule

`default_nettype wire

// File: tb/tb_fill_processor.sv
// ============================================================================
// Module   : tb_fill_processor
// Brief    : Directed self-checking bench for fill_processor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fill_processor;
   import fill_processor_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               i_er_valid = 1'b0;
   logic               o_er_ready;
   logic [1:0]         i_er_type = 2'd0;
   order_side_e        i_er_side = SIDE_BUY;
   logic [31:0]        i_er_qty = '0;
   logic [31:0]        i_er_price = '0;
   logic [31:0]        i_er_seq = '0;
   logic [31:0]        i_mark_px = '0;
   logic               i_cmd_pos_reset = 1'b0;
   logic               i_cmd_clear_err = 1'b0;
   logic               o_fill_valid;
   order_side_e        o_fill_side;
   logic [63:0]        o_fill_qty, o_fill_notional, o_current_pnl;
   logic signed [47:0] o_net_position;
   logic               o_pnl_is_loss, o_seq_gap_flag;
   logic [63:0]        o_stat_fills, o_stat_dups, o_stat_gaps;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fill_processor dut (
      .clk(clk), .rst(rst),
      .i_er_valid(i_er_valid), .o_er_ready(o_er_ready), .i_er_type(i_er_type),
      .i_er_side(i_er_side), .i_er_qty(i_er_qty), .i_er_price(i_er_price), .i_er_seq(i_er_seq),
      .i_mark_px(i_mark_px), .i_cmd_pos_reset(i_cmd_pos_reset), .i_cmd_clear_err(i_cmd_clear_err),
      .o_fill_valid(o_fill_valid), .o_fill_side(o_fill_side), .o_fill_qty(o_fill_qty),
      .o_fill_notional(o_fill_notional), .o_net_position(o_net_position),
      .o_current_pnl(o_current_pnl), .o_pnl_is_loss(o_pnl_is_loss), .o_seq_gap_flag(o_seq_gap_flag),
      .o_stat_fills(o_stat_fills), .o_stat_dups(o_stat_dups), .o_stat_gaps(o_stat_gaps)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] seq, input logic [1:0] typ, input order_side_e side,
                        input logic [31:0] qty, input logic [31:0] px);
      i_er_valid = 1'b1;
      i_er_seq   = seq;
      i_er_type  = typ;
      i_er_side  = side;
      i_er_qty   = qty;
      i_er_price = px;
   endtask

   task automatic idle();
      i_er_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_ready", o_er_ready, 0);
      check("rst_fill_valid", o_fill_valid, 0);
      check("rst_pos", o_net_position, 0);
      check("rst_pnl", o_current_pnl, 0);
      check("rst_loss", o_pnl_is_loss, 0);
      check("rst_gap", o_seq_gap_flag, 0);
      check("rst_stats", {o_stat_fills, o_stat_dups | o_stat_gaps}, 0);
      rst = 1'b0;
      step();
      check("ready_rise", o_er_ready, 1);

      // Single BUY 10@100, marked at 100
      i_mark_px = 32'd100;
      drive(32'd5, 2'd0, SIDE_BUY, 32'd10, 32'd100);
      step();
      idle();
      check("t1_fv", o_fill_valid, 1);
      check("t1_side", o_fill_side, SIDE_BUY);
      check("t1_qty", o_fill_qty, 10);
      check("t1_notional", o_fill_notional, 1000);
      check("t1_fills", o_stat_fills, 1);
      step();
      check("t1_fv_drop", o_fill_valid, 0);
      check("t1_pos", o_net_position, 10);
      step();
      check("t1_pnl", o_current_pnl, 0);
      check("t1_loss", o_pnl_is_loss, 0);

      // Back-to-back BUY then SELL
      do_reset();
      i_mark_px = 32'd100;
      drive(32'd5, 2'd0, SIDE_BUY, 32'd10, 32'd100);
      step();
      drive(32'd6, 2'd1, SIDE_SELL, 32'd10, 32'd110);
      check("t2_fv1", o_fill_valid, 1);
      check("t2_not1", o_fill_notional, 1000);
      step();
      idle();
      check("t2_fv2", o_fill_valid, 1);
      check("t2_side2", o_fill_side, SIDE_SELL);
      check("t2_not2", o_fill_notional, 1100);
      check("t2_pos_mid", o_net_position, 10);
      step();
      check("t2_fv_drop", o_fill_valid, 0);
      check("t2_pos", o_net_position, 0);
      check("t2_fills", o_stat_fills, 2);
      step();
      step();
      check("t2_pnl", o_current_pnl, 100);
      check("t2_loss", o_pnl_is_loss, 0);

      // Gap, duplicate, clear_err and clear-vs-gap priority
      do_reset();
      drive(32'd5, 2'd0, SIDE_BUY, 32'd1, 32'd10);
      step();
      drive(32'd7, 2'd0, SIDE_BUY, 32'd2, 32'd10);
      step();
      idle();
      check("t3_gap_flag", o_seq_gap_flag, 1);
      check("t3_gaps", o_stat_gaps, 1);
      check("t3_gap_fv", o_fill_valid, 1);
      check("t3_gap_qty", o_fill_qty, 2);
      drive(32'd6, 2'd0, SIDE_BUY, 32'd4, 32'd10);
      step();
      idle();
      check("t3_dup_fv", o_fill_valid, 0);
      check("t3_dups", o_stat_dups, 1);
      check("t3_dup_fills", o_stat_fills, 2);
      step();
      step();
      check("t3_pos", o_net_position, 3);
      i_cmd_clear_err = 1'b1;
      step();
      i_cmd_clear_err = 1'b0;
      check("t3_clear", o_seq_gap_flag, 0);
      drive(32'd10, 2'd2, SIDE_BUY, 32'd0, 32'd0);
      i_cmd_clear_err = 1'b1;
      step();
      idle();
      i_cmd_clear_err = 1'b0;
      check("t3_gap_wins", o_seq_gap_flag, 1);
      check("t3_gaps2", o_stat_gaps, 2);
      check("t3_cancel_fv", o_fill_valid, 0);
      check("t3_cancel_fills", o_stat_fills, 2);

      // Sequence wrap 0xFFFFFFFF -> 0
      do_reset();
      drive(32'hFFFF_FFFF, 2'd0, SIDE_BUY, 32'd1, 32'd1);
      step();
      drive(32'd0, 2'd0, SIDE_BUY, 32'd1, 32'd1);
      step();
      idle();
      check("t4_fv", o_fill_valid, 1);
      check("t4_gaps", o_stat_gaps, 0);
      check("t4_dups", o_stat_dups, 0);
      check("t4_fills", o_stat_fills, 2);
      check("t4_flag", o_seq_gap_flag, 0);

      // Loss marking, then position reset colliding with a stage-2 update
      do_reset();
      i_mark_px = 32'd90;
      drive(32'd5, 2'd0, SIDE_BUY, 32'd10, 32'd100);
      step();
      idle();
      step();
      step();
      check("t5_pos", o_net_position, 10);
      check("t5_loss", o_pnl_is_loss, 1);
      check("t5_pnl", o_current_pnl, 100);
      drive(32'd6, 2'd0, SIDE_SELL, 32'd3, 32'd50);
      step();
      idle();
      check("t5_fv", o_fill_valid, 1);
      i_cmd_pos_reset = 1'b1;
      step();
      i_cmd_pos_reset = 1'b0;
      check("t5_pos_reset", o_net_position, 0);
      step();
      check("t5_pnl_reset", o_current_pnl, 0);
      check("t5_loss_reset", o_pnl_is_loss, 0);

      // Reset with three reports in flight
      do_reset();
      drive(32'd1, 2'd0, SIDE_BUY, 32'd1, 32'd1);
      step();
      drive(32'd2, 2'd0, SIDE_BUY, 32'd1, 32'd1);
      step();
      drive(32'd3, 2'd0, SIDE_BUY, 32'd1, 32'd1);
      step();
      idle();
      rst = 1'b1;
      #1;
      check("t6_fv_flush", o_fill_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_fv_hold", o_fill_valid, 0);
      end
      check("t6_stats", {o_stat_fills, o_stat_dups | o_stat_gaps}, 0);
      check("t6_pos", o_net_position, 0);
      rst = 1'b0;
      step();
      drive(32'd1000, 2'd0, SIDE_BUY, 32'd5, 32'd2);
      step();
      idle();
      check("t6_fv", o_fill_valid, 1);
      check("t6_gaps", o_stat_gaps, 0);
      check("t6_flag", o_seq_gap_flag, 0);
      check("t6_fills", o_stat_fills, 1);
      step();
      step();
      check("t6_post_pos", o_net_position, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
